sobel_stream: RTL
=================

Name: sobel_stream

Overview:
Streaming, parametrised Sobel edge detector that replaces the memory-walking, 9-reads-per-pixel version.
- Accepts one raster-scan pixel per cycle over a valid/ready handshake.
- Holds two line buffers and a 3x3 window, and emits one result per interior pixel.
- Output is either saturated gradient magnitude or a binary edge map.
- Sits between the image-memory reader and the output-memory writer.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_W, 256, image width in pixels (>=3)
IMG_H, 256, image height in pixels (>=3)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
mode_i  input  1  0 = magnitude output, 1 = thresholded binary output; sampled at frame start
threshold_i  input  DATA_WIDTH+4  edge threshold; sampled at frame start
in_valid_i  input  1  input pixel valid
in_ready_o  output  1  block can accept pixel
in_pixel_i  input  DATA_WIDTH  raster-scan pixel, row-major, row 0 first
out_valid_o  output  1  output pixel valid
out_ready_i  input  1  downstream accepts output
out_pixel_o  output  DATA_WIDTH  result pixel
out_last_o  output  1  high with the final interior pixel of a frame
dir_o  output  2  quantised gradient direction (see Optional Feature)
frame_done_o  output  1  one-cycle pulse when last output is accepted

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high on rst_i.
- Reset values:
  - in_ready_o=1.
  - out_valid_o=0, out_last_o=0, frame_done_o=0.
  - out_pixel_o=0, dir_o=0.
  - Column/row counters=0.
  - Line buffer contents are don't-care.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is (0,0).
- Input acceptance: a pixel is accepted when in_valid_i && in_ready_o.
- Stall rule: in_ready_o = !out_valid_o || out_ready_i. When in_ready_o is low the whole pipeline freezes, with no bubbles inserted and no data lost.
- Counters:
  - col counts 0..IMG_W-1; row counts 0..IMG_H-1.
  - Both wrap to 0 after pixel (IMG_H-1, IMG_W-1); the next frame starts immediately.
  - mode_i and threshold_i are latched when pixel (0,0) is accepted.
- Line buffers:
  - Two IMG_W-deep buffers hold rows r-1 and r-2.
  - Read and write happen at index col in the same accept cycle.
  - The 3x3 window shifts left by one column on each accept.
- Window emission:
  - A window is emitted when the accepted pixel has row>=2 and col>=2.
  - The emitted window is centred on (row-1, col-1).
  - That gives (IMG_W-2)*(IMG_H-2) outputs per frame; no border outputs.
- Pipeline:
  - Stage 1 registers gx and gy, each signed DATA_WIDTH+3 bits.
  - Stage 2 computes mag = |gx|+|gy|, unsigned DATA_WIDTH+4 bits, and registers the output.
  - Latency: 2 accepted-cycles from the triggering pixel to out_valid_o.
- Kernels, rows listed top to bottom:
  - Gx = [-1 0 1; -2 0 2; -1 0 1].
  - Gy = [-1 -2 -1; 0 0 0; 1 2 1].
- Output mapping:
  - Magnitude mode: out_pixel_o = min(mag, 2^DATA_WIDTH-1).
  - Threshold mode: out_pixel_o = 0 if mag >= threshold, else all ones (edges black on white).
- out_last_o is asserted with the output from window centre (IMG_H-2, IMG_W-2).
- frame_done_o pulses in the cycle after that output handshake completes.
- out_valid_o and all output data stay stable while out_valid_o=1 and out_ready_i=0.

Optional Feature:
SOBEL_DIR_EN
- Defined: dir_o is registered alongside out_pixel_o.
  - 0 = horizontal edge, when |gy| > 2|gx|.
  - 1 = vertical edge, when |gx| > 2|gy|.
  - 2 = diagonal with gx*gy >= 0.
  - 3 = diagonal with gx*gy < 0.
- Undefined: dir_o is tied to 0 and no direction logic is synthesised.

Test Plan:
All scenarios use DATA_WIDTH=8, IMG_W=8, IMG_H=6.
- Flat frame, all pixels 100, mode 0, out_ready_i=1 -> exactly 24 outputs, all 0; out_last_o on the 24th; frame_done_o pulses once.
- Vertical step (cols 0-3 = 0, cols 4-7 = 200), mode 0 -> window columns 3,4 have gx=800, so out=255 (saturated); all others 0.
- Same step image, mode 1, threshold=400 -> columns 3,4 give 0; all others give 255.
- Random stimulus with in_valid_i and out_ready_i toggled randomly at 50% -> output stream bit-identical to the out_ready_i=1 run; no output changes while stalled.
- Assert rst_i after 20 accepted pixels, then send a full flat-50 frame -> 24 outputs of 0, none from the aborted frame.
- With SOBEL_DIR_EN, run the step image -> dir_o=1 on edge outputs. Horizontal step (rows 0-2 = 0, rows 3-5 = 200) -> dir_o=0.

Source files
------------

// File: rtl/sobel_stream_if.sv
// Valid/ready pixel streams into and out of the Sobel edge detector.
// slave: the detector side; master: the producer/consumer side.
interface sobel_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_pixel_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_pixel_o;
  logic                  out_last_o;
  logic [1:0]            dir_o;
  logic                  frame_done_o;

  modport slave (
    input  in_valid_i, in_pixel_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pixel_o, out_last_o, dir_o, frame_done_o
  );

  modport master (
    output in_valid_i, in_pixel_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pixel_o, out_last_o, dir_o, frame_done_o
  );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, 2-stage gradient pipeline.
// Define SOBEL_DIR_EN to add the quantised gradient direction output on dir_o.
module sobel_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 256,
  parameter int unsigned IMG_H      = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH+3:0] threshold_i,
  sobel_stream_if.slave         bus
);
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned GW = DATA_WIDTH + 3;
  localparam int unsigned MW = DATA_WIDTH + 4;
  localparam int unsigned PIX_MAX = (2 ** DATA_WIDTH) - 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          mode_q;
  logic [MW-1:0] thr_q;

  pix_t lb1 [IMG_W];
  pix_t lb2 [IMG_W];
  pix_t wl  [3];
  pix_t wm  [3];

  logic advance, accept, emit;
  pix_t top_n, mid_n, pix_n;

  logic                 s1_valid, s1_last;
  logic signed [GW-1:0] s1_gx, s1_gy;
  logic signed [GW-1:0] gx_n, gy_n;

  logic [GW-1:0] ax, ay;
  logic [MW-1:0] mag;
  pix_t          out_n;

  function automatic logic signed [GW-1:0] wsum(input pix_t a, input pix_t b, input pix_t c);
    logic signed [GW-1:0] r;
    r = $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
    return r;
  endfunction

  // The whole pipeline advances whenever the output register can take a value,
  // so a frame's tail drains without needing pixels from the next frame.
  assign advance        = !bus.out_valid_o || bus.out_ready_i;
  assign bus.in_ready_o = advance;
  assign accept         = bus.in_valid_i && advance;
  assign emit           = accept && (row >= RW'(2)) && (col >= CW'(2));

  assign pix_n = bus.in_pixel_i;
  assign top_n = lb2[col];
  assign mid_n = lb1[col];

  // Gradients of the window as it will stand after this accept:
  // left column wl, centre column wm, right column {top_n, mid_n, pix_n}.
  always_comb begin
    gx_n = wsum(top_n, mid_n, pix_n) - wsum(wl[0], wl[1], wl[2]);
    gy_n = wsum(wl[2], wm[2], pix_n) - wsum(wl[0], wm[0], top_n);
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[col] <= pix_n;
      lb2[col] <= mid_n;
      wl[0]    <= wm[0];
      wl[1]    <= wm[1];
      wl[2]    <= wm[2];
      wm[0]    <= top_n;
      wm[1]    <= mid_n;
      wm[2]    <= pix_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col    <= '0;
      row    <= '0;
      mode_q <= 1'b0;
      thr_q  <= '0;
    end else if (accept) begin
      if (row == '0 && col == '0) begin
        mode_q <= mode_i;
        thr_q  <= threshold_i;
      end
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_gx    <= '0;
      s1_gy    <= '0;
    end else if (advance) begin
      s1_valid <= emit;
      s1_last  <= emit && (row == ROW_LAST) && (col == COL_LAST);
      if (emit) begin
        s1_gx <= gx_n;
        s1_gy <= gy_n;
      end
    end
  end

  always_comb begin
    ax  = s1_gx[GW-1] ? (~s1_gx + GW'(1)) : s1_gx;
    ay  = s1_gy[GW-1] ? (~s1_gy + GW'(1)) : s1_gy;
    mag = MW'(ax) + MW'(ay);
    if (mode_q) begin
      out_n = (mag >= thr_q) ? '0 : '1;
    end else begin
      out_n = (mag > MW'(PIX_MAX)) ? '1 : mag[DATA_WIDTH-1:0];
    end
  end

  logic out_valid_q, out_last_q, frame_done_q;
  pix_t out_pixel_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_pixel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_valid_q && bus.out_ready_i && out_last_q;
      if (advance) begin
        out_valid_q <= s1_valid;
        out_last_q  <= s1_valid && s1_last;
        if (s1_valid) begin
          out_pixel_q <= out_n;
        end
      end
    end
  end

  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_last_o   = out_last_q;
  assign bus.out_pixel_o  = out_pixel_q;
  assign bus.frame_done_o = frame_done_q;

`ifdef SOBEL_DIR_EN
  logic [1:0]    dir_n, dir_q;
  logic [MW-1:0] ax2, ay2;

  always_comb begin
    ax2 = {ax, 1'b0};
    ay2 = {ay, 1'b0};
    if (MW'(ay) > ax2) begin
      dir_n = 2'd0;
    end else if (MW'(ax) > ay2) begin
      dir_n = 2'd1;
    end else if ((s1_gx[GW-1] == s1_gy[GW-1]) || (s1_gx == '0) || (s1_gy == '0)) begin
      dir_n = 2'd2;
    end else begin
      dir_n = 2'd3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_q <= '0;
    end else if (advance && s1_valid) begin
      dir_q <= dir_n;
    end
  end

  assign bus.dir_o = dir_q;
`else
  assign bus.dir_o = '0;
`endif

endmodule
